// File: rtl/fp16_add_arbiter.sv
// fifo: generic response queue with wrapping pointers; head reads as zero when empty.
// Latency: push visible at head the cycle after; pop-when-empty ignored.
// Backpressure: none internally; the producer guarantees it never pushes into a full queue.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  push_never_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));
endmodule

// fp16_add_arbiter: round-robin sharing of one external fp16 adder among NREQ requesters.
// Latency: request transfer to rsp_valid is ADD_LAT+1 cycles; up to one issue per cycle.
// Backpressure: issue withheld while in-flight ops plus queued responses fill FIFO_DEPTH.
module fp16_add_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [15:0]          add_x,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    sum;
  } rsp_t;

  logic [IDW-1:0]     rr_ptr, grant_idx;
  logic               grant_found, credit_ok, issue;
  logic [ADD_LAT-1:0] tag_v;
  logic [IDW-1:0]     tag_id [ADD_LAT];
  logic [CW-1:0]      fifo_count, inflight;
  logic               fifo_empty;
  rsp_t               push_entry, head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ADD_LAT; i++) inflight = inflight + CW'(tag_v[i]);
  end

  // A pop in this cycle only shows up in fifo_count next cycle, so it cannot fund a same-cycle issue.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    logic [IDW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign issue = rst && credit_ok && grant_found;

  always_comb begin
    req_ready = '0;
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && grant_idx == IDW'(i)) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[16*i +: 16];
        add_b        = req_b[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= '0;
    else if (issue)
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Tag pipe mirrors the adder latency and never stalls; credits guarantee a FIFO slot at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= grant_idx;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push_entry = '{id: tag_id[ADD_LAT-1], sum: add_x};

  fifo #(.W($bits(rsp_t)), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tag_v[ADD_LAT-1]),
    .push_dat (push_entry),
    .pop      (rsp_ready),
    .pop_dat  (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head.sum;
  assign rsp_id    = head.id;
  assign busy      = (|tag_v) || !fifo_empty;
endmodule
